// File: rtl/control_subcmd_scheduler.sv
// control_subcmd_scheduler
//   Runs one framebuffer subcommand engine at a time and lends it the single
//   RAM write port. A command names an engine; the scheduler raises that
//   engine's enable, forwards its write stream to the RAM, acknowledges its
//   done, then drops enable and reports completion. A watchdog aborts engines
//   that never report done.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   req_valid/engine    command request and target engine index
//   req_ready, busy     ready in IDLE, busy otherwise
//   eng_enable/eng_ack  one-hot enable and ack to the engines
//   eng_done/eng_we     per-engine done and write strobe
//   eng_row/column/pixel/data  flattened per-engine write address/data
//   row/column/pixel/data_out/ram_write_enable  RAM write port
//   cmd_done/cmd_error  completion pulse; error = timeout or bad index
module control_subcmd_scheduler #(
  parameter int unsigned NUM_ENGINES     = 3,
  parameter int unsigned PIXEL_WIDTH     = 64,
  parameter int unsigned PIXEL_HEIGHT    = 32,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned TIMEOUT_CYCLES  = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL + 16,
  localparam int unsigned SEL_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1,
  localparam int unsigned ROW_W  = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int unsigned COL_W  = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int unsigned PIX_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1,
  localparam int unsigned DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [SEL_W-1:0]              req_engine,
  output logic                          req_ready,
  output logic                          busy,
  output logic [NUM_ENGINES-1:0]        eng_enable,
  output logic [NUM_ENGINES-1:0]        eng_ack,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES-1:0]        eng_we,
  input  logic [NUM_ENGINES*ROW_W-1:0]  eng_row,
  input  logic [NUM_ENGINES*COL_W-1:0]  eng_column,
  input  logic [NUM_ENGINES*PIX_W-1:0]  eng_pixel,
  input  logic [NUM_ENGINES*DATA_W-1:0] eng_data,
  output logic [ROW_W-1:0]              row,
  output logic [COL_W-1:0]              column,
  output logic [PIX_W-1:0]              pixel,
  output logic [DATA_W-1:0]             data_out,
  output logic                          ram_write_enable,
  output logic                          cmd_done,
  output logic                          cmd_error
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SEL_W-1:0]       r_sel, w_sel_nxt;
  logic [TMR_W-1:0]       r_timer, w_timer_nxt;
  logic                   r_err, w_err_nxt;
  logic [NUM_ENGINES-1:0] r_eng_enable, w_eng_enable_nxt;
  logic [NUM_ENGINES-1:0] r_eng_ack, w_eng_ack_nxt;
  logic                   r_cmd_done, w_cmd_done_nxt;
  logic                   r_cmd_error, w_cmd_error_nxt;

  logic                   w_req_invalid;
  logic                   w_timeout;
  logic [NUM_ENGINES-1:0] w_req_onehot;
  logic [NUM_ENGINES-1:0] w_sel_onehot;
  logic                   w_sel_done;
  logic                   w_sel_we;
  logic [ROW_W-1:0]       w_sel_row;
  logic [COL_W-1:0]       w_sel_col;
  logic [PIX_W-1:0]       w_sel_pix;
  logic [DATA_W-1:0]      w_sel_data;

  // Widened compare so the check also works when NUM_ENGINES is a power of two.
  assign w_req_invalid = ({1'b0, req_engine} >= (SEL_W + 1)'(NUM_ENGINES));
  assign w_timeout     = WD_EN && (r_timer == TMR_LAST);

  // Selected-engine mux; only slice r_sel can ever reach the RAM port.
  always_comb begin
    w_req_onehot = '0;
    w_sel_onehot = '0;
    w_sel_done   = 1'b0;
    w_sel_we     = 1'b0;
    w_sel_row    = '0;
    w_sel_col    = '0;
    w_sel_pix    = '0;
    w_sel_data   = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      w_req_onehot[i] = (req_engine == SEL_W'(i));
      w_sel_onehot[i] = (r_sel == SEL_W'(i));
      if (r_sel == SEL_W'(i)) begin
        w_sel_done = eng_done[i];
        w_sel_we   = eng_we[i];
        w_sel_row  = eng_row[i*ROW_W +: ROW_W];
        w_sel_col  = eng_column[i*COL_W +: COL_W];
        w_sel_pix  = eng_pixel[i*PIX_W +: PIX_W];
        w_sel_data = eng_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_eng_enable <= '0;
      r_eng_ack    <= '0;
      r_cmd_done   <= 1'b0;
      r_cmd_error  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_timer      <= w_timer_nxt;
      r_err        <= w_err_nxt;
      r_eng_enable <= w_eng_enable_nxt;
      r_eng_ack    <= w_eng_ack_nxt;
      r_cmd_done   <= w_cmd_done_nxt;
      r_cmd_error  <= w_cmd_error_nxt;
    end
  end

  // Enable/ack/done are computed here as next-state values so that they
  // change on the same edge as the state they belong to.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_timer_nxt      = r_timer;
    w_err_nxt        = r_err;
    w_eng_enable_nxt = r_eng_enable;
    w_eng_ack_nxt    = '0;
    w_cmd_done_nxt   = 1'b0;
    w_cmd_error_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_invalid) begin
            w_cmd_done_nxt  = 1'b1;
            w_cmd_error_nxt = 1'b1;
          end else begin
            w_sel_nxt        = req_engine;
            w_timer_nxt      = '0;
            w_err_nxt        = 1'b0;
            w_eng_enable_nxt = w_req_onehot;
            w_state_nxt      = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_timer != '1) begin
          w_timer_nxt = r_timer + 1'b1;
        end
        // Done has priority over a coincident timeout.
        if (w_sel_done) begin
          w_eng_ack_nxt = w_sel_onehot;
          w_state_nxt   = S_ACK;
        end else if (w_timeout) begin
          w_err_nxt        = 1'b1;
          w_eng_enable_nxt = '0;
          w_cmd_done_nxt   = 1'b1;
          w_cmd_error_nxt  = 1'b1;
          w_state_nxt      = S_RELEASE;
        end
      end
      S_ACK: begin
        w_eng_enable_nxt = '0;
        w_cmd_done_nxt   = 1'b1;
        w_cmd_error_nxt  = r_err;
        w_state_nxt      = S_RELEASE;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_eng_enable_nxt = '0;
        w_state_nxt      = S_IDLE;
      end
    endcase
  end

  // Write port forwards only while RUN; zero otherwise.
  always_comb begin
    ram_write_enable = 1'b0;
    row              = '0;
    column           = '0;
    pixel            = '0;
    data_out         = '0;
    if (r_state == S_RUN) begin
      ram_write_enable = w_sel_we;
      row              = w_sel_row;
      column           = w_sel_col;
      pixel            = w_sel_pix;
      data_out         = w_sel_data;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign eng_enable = r_eng_enable;
  assign eng_ack    = r_eng_ack;
  assign cmd_done   = r_cmd_done;
  assign cmd_error  = r_cmd_error;

endmodule

// File: tb/tb_control_subcmd_scheduler.sv
// Scoreboard bench for control_subcmd_scheduler: each command's expected
// RAM writes and completion record are queued when it is issued; a monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_control_subcmd_scheduler;
  localparam int unsigned NE  = 3;
  localparam int unsigned PW  = 4;
  localparam int unsigned PH  = 2;
  localparam int unsigned BPP = 1;
  localparam int unsigned TO  = 8;
  localparam int unsigned SW  = 2;
  localparam int unsigned RW  = 1;
  localparam int unsigned CW  = 2;
  localparam int unsigned PXW = 1;
  localparam int unsigned DW  = 8;
  localparam int unsigned WRW = RW + CW + PXW + DW;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic [SW-1:0]    req_engine = '0;
  logic             req_ready, busy;
  logic [NE-1:0]    eng_enable, eng_ack;
  logic [NE-1:0]    eng_done = '0;
  logic [NE-1:0]    eng_we = '0;
  logic [NE*RW-1:0] eng_row = '0;
  logic [NE*CW-1:0] eng_column = '0;
  logic [NE*PXW-1:0] eng_pixel = '0;
  logic [NE*DW-1:0] eng_data = '0;
  logic [RW-1:0]    row;
  logic [CW-1:0]    column;
  logic [PXW-1:0]   pixel;
  logic [DW-1:0]    data_out;
  logic             ram_write_enable, cmd_done, cmd_error;

  control_subcmd_scheduler #(
    .NUM_ENGINES(NE), .PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH),
    .BYTES_PER_PIXEL(BPP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_engine(req_engine),
    .req_ready(req_ready), .busy(busy), .eng_enable(eng_enable), .eng_ack(eng_ack),
    .eng_done(eng_done), .eng_we(eng_we), .eng_row(eng_row), .eng_column(eng_column),
    .eng_pixel(eng_pixel), .eng_data(eng_data), .row(row), .column(column),
    .pixel(pixel), .data_out(data_out), .ram_write_enable(ram_write_enable),
    .cmd_done(cmd_done), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // Engine behaviour for one command: d = RUN cycle (1-based) of done, 0 = never.
  typedef struct packed {
    logic [2:0]             eng;
    logic [4:0]             d;
    logic [15:0]            we;
    logic [15:0][WRW-1:0]   wr;
  } script_t;

  typedef struct packed {
    logic [2:0] eng;
    logic       err;
    logic [4:0] run;
    logic [1:0] acks;
    logic [4:0] nwr;
  } cmd_exp_t;

  script_t        scripts[$];
  cmd_exp_t       exp_cmd[$];
  logic [WRW-1:0] exp_wr[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NE-1:0] onehot(input int unsigned e);
    onehot = '0;
    if (e < NE) onehot[e] = 1'b1;
  endfunction

  task automatic make_script(input int unsigned eng, input int unsigned d,
                             input bit fill, output script_t s);
    logic [3:0] kb;
    s.eng = 3'(eng);
    s.d   = 5'(d);
    for (int k = 0; k < 16; k++) begin
      kb = 4'(k);
      if (fill) begin
        s.we[k] = 1'b1;
        s.wr[k] = {kb[2], kb[1:0], 1'b0, 8'hA5};
      end else begin
        s.we[k] = 1'($urandom_range(0, 1));
        s.wr[k] = WRW'($urandom);
      end
    end
  endtask

  // Reference: a command runs until its done cycle, or TO cycles if done
  // never comes in time; every write inside that window reaches the RAM.
  task automatic push_expect(input script_t s);
    cmd_exp_t    c;
    int unsigned run;
    int unsigned nwr;
    c.eng = s.eng;
    nwr   = 0;
    if (s.eng >= NE) begin
      run = 0; c.err = 1'b1; c.acks = 2'd0;
    end else if (s.d != 0 && s.d <= TO) begin
      run = s.d; c.err = 1'b0; c.acks = 2'd1;
    end else begin
      run = TO; c.err = 1'b1; c.acks = 2'd0;
    end
    for (int unsigned k = 0; k < run; k++) begin
      if (s.we[k]) begin
        exp_wr.push_back(s.wr[k]);
        nwr++;
      end
    end
    c.run = 5'(run);
    c.nwr = 5'(nwr);
    exp_cmd.push_back(c);
    if (s.eng < NE) scripts.push_back(s);
  endtask

  // Engine models: the scripted engine follows its script once enabled;
  // every other input is noise the DUT must ignore.
  initial begin
    script_t     cur;
    bit          active;
    int unsigned step;
    int          e;
    active = 1'b0;
    step   = 0;
    cur    = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NE; i++) begin
        eng_we[i]              = 1'($urandom_range(0, 1));
        eng_done[i]            = 1'($urandom_range(0, 1));
        eng_row[i*RW +: RW]    = RW'($urandom);
        eng_column[i*CW +: CW] = CW'($urandom);
        eng_pixel[i*PXW +: PXW] = PXW'($urandom);
        eng_data[i*DW +: DW]   = DW'($urandom);
      end
      if (!reset) begin
        active = 1'b0;
      end else begin
        if (active && eng_enable == '0) active = 1'b0;
        if (!active && eng_enable != '0 && scripts.size() != 0) begin
          cur    = scripts.pop_front();
          active = 1'b1;
          step   = 0;
        end
        if (active) begin
          e = int'(cur.eng);
          if (cur.d == 0 || step < cur.d) begin
            eng_done[e] = (cur.d != 0 && step == cur.d - 1);
            eng_we[e]   = (step < 16) ? cur.we[step] : 1'b0;
            if (step < 16)
              {eng_row[e*RW +: RW], eng_column[e*CW +: CW],
               eng_pixel[e*PXW +: PXW], eng_data[e*DW +: DW]} = cur.wr[step];
          end
          step++;
        end
      end
    end
  end

  // Monitor
  initial begin
    int unsigned run_cnt, ack_cnt, wr_cnt;
    cmd_exp_t    mc;
    run_cnt = 0; ack_cnt = 0; wr_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_cnt = 0; ack_cnt = 0; wr_cnt = 0;
      end else begin
        chk("ready_vs_busy", req_ready, !busy);
        chk("enable_onehot", ($countones(eng_enable) <= 1), 1);
        if (eng_ack != '0) chk("ack_with_enable", eng_ack, eng_enable);
        if (eng_enable != '0) chk("ready_low_when_enabled", req_ready, 0);
        if (eng_enable != '0 && exp_cmd.size() != 0)
          chk("enable_sel", eng_enable, onehot(exp_cmd[0].eng));
        if (eng_enable != '0 && eng_ack == '0) run_cnt++;
        if (eng_ack != '0) ack_cnt++;
        if (!(eng_enable != '0 && eng_ack == '0))
          chk("port_zero_outside_run", {ram_write_enable, row, column, pixel, data_out}, 0);
        if (ram_write_enable) begin
          wr_cnt++;
          chk("write_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0)
            chk("ram_write", {row, column, pixel, data_out}, exp_wr.pop_front());
        end
        if (cmd_error) chk("error_has_done", cmd_done, 1);
        if (cmd_done) begin
          chk("cmd_expected", exp_cmd.size() != 0, 1);
          if (exp_cmd.size() != 0) begin
            mc = exp_cmd.pop_front();
            chk("cmd_error", cmd_error, mc.err);
            chk("run_cycles", run_cnt, mc.run);
            chk("ack_cycles", ack_cnt, mc.acks);
            chk("write_count", wr_cnt, mc.nwr);
            chk("enable_at_done", eng_enable, 0);
            chk("ready_at_done", req_ready, (mc.eng >= NE));
          end
          run_cnt = 0; ack_cnt = 0; wr_cnt = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic wait_ready();
    for (int c = 0; c < 40 && !req_ready; c++) begin
      @(posedge clk);
      #1;
    end
    chk("ready_wait", req_ready, 1);
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 60 && done_cnt < target; c++) begin
      @(posedge clk);
      #1;
    end
    chk("cmd_done_wait", (done_cnt >= target), 1);
  endtask

  task automatic run_cmd(input int unsigned eng, input int unsigned d, input bit fill);
    script_t s;
    int      target;
    make_script(eng, d, fill, s);
    push_expect(s);
    target = done_cnt + 1;
    @(posedge clk);
    #1;
    wait_ready();
    req_valid  = 1'b1;
    req_engine = SW'(eng);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (eng < NE) begin
      chk("accept_enable", eng_enable, onehot(eng));
    end else begin
      chk("reject_done", {cmd_done, cmd_error}, 2'b11);
      chk("reject_ready", req_ready, 1);
      chk("reject_enable", eng_enable, 0);
    end
    wait_done(target);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    script_t s;
    int      target, d0, acc;
    bit      prev_en, h1, h2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", eng_enable, 0);
    chk("rst_ack", eng_ack, 0);
    chk("rst_done", {cmd_done, cmd_error}, 0);
    chk("rst_port", {ram_write_enable, row, column, pixel, data_out}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Fill of the whole 4x2x1 frame with A5; done lands on the timeout cycle.
    run_cmd(0, 8, 1'b1);
    // Engine 1 normal, others noisy
    run_cmd(1, 6, 1'b0);
    run_cmd(1, 1, 1'b0);
    // Invalid index
    run_cmd(3, 0, 1'b0);
    // Watchdog
    run_cmd(2, 0, 1'b0);

    // Reset in the middle of RUN
    make_script(1, 0, 1'b0, s);
    push_expect(s);
    @(posedge clk);
    #1;
    wait_ready();
    req_valid = 1'b1;
    req_engine = SW'(1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("abort_enable", eng_enable, 0);
    chk("abort_ack", eng_ack, 0);
    chk("abort_port", {ram_write_enable, row, column, pixel, data_out}, 0);
    chk("abort_done", cmd_done, 0);
    exp_wr.delete();
    exp_cmd.delete();
    scripts.delete();
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt, d0);
    run_cmd(2, 4, 1'b0);

    // req_valid held high across two commands
    make_script(0, 3, 1'b0, s);
    push_expect(s);
    make_script(0, 2, 1'b0, s);
    push_expect(s);
    target = done_cnt + 2;
    @(posedge clk);
    #1;
    wait_ready();
    req_valid  = 1'b1;
    req_engine = SW'(0);
    acc = 0; prev_en = 1'b0; h1 = 1'b0; h2 = 1'b0;
    for (int c = 0; c < 40 && acc < 2; c++) begin
      @(posedge clk);
      #1;
      if (eng_enable != '0 && !prev_en) begin
        acc++;
        if (acc == 2) begin
          chk("b2b_accept_after_release", h2, 1);
          chk("b2b_idle_gap", h1, 0);
          req_valid = 1'b0;
        end
      end
      prev_en = (eng_enable != '0);
      h2 = h1;
      h1 = cmd_done;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 2);
    wait_done(target);

    // Random commands
    for (int n = 0; n < 30; n++)
      run_cmd($urandom_range(0, 3), $urandom_range(0, 11), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
